// File: rtl/pwm_deadtime_gen.sv
// Single-channel PWM with shadowed offset/duty and dead-time insertion.
// Complementary gates are registered and never overlap.
module pwm_deadtime_gen #(
  parameter int SIZE   = 13,
  parameter int PERIOD = 5000,
  parameter int DEAD   = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [SIZE-1:0] offset,
  input  logic [SIZE-1:0] duty,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            sync,
  output logic [SIZE-1:0] cnt,
  output logic            cfg_err
);

  localparam logic [SIZE-1:0] PMAX = SIZE'(PERIOD - 1);
  localparam logic [SIZE:0]   PER  = (SIZE+1)'(PERIOD);
  localparam int              DW   = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [DW-1:0]   DT_LOAD = DW'(DEAD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DT,
    HI,
    LO
  } st_e;

  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] off_s_q, dty_s_q;
  logic            cfg_q, sync_q, r_q;
  logic            h_q, l_q, tgt_q;
  logic [DW-1:0]   dt_q;
  st_e             st_q;

  logic            wrap;
  logic            load;
  logic            r;
  logic [SIZE:0]   end_w;
  logic [SIZE:0]   cnt_w;

  assign wrap  = (cnt_q == PMAX);
  assign load  = !en || wrap;
  assign cnt_d = (!en || wrap) ? '0 : cnt_q + SIZE'(1);
  assign end_w = {1'b0, off_s_q} + {1'b0, dty_s_q};
  assign cnt_w = {1'b0, cnt_q};

  always_comb begin
    r = 1'b0;
    if (({1'b0, off_s_q} >= PER) || (dty_s_q == '0))
      r = 1'b0;
    else if ({1'b0, dty_s_q} >= PER)
      r = 1'b1;
    else if (end_w <= PER)
      r = (cnt_q >= off_s_q) && (cnt_w < end_w);
    else
      r = (cnt_q >= off_s_q) || (cnt_w < end_w - PER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      off_s_q <= '0;
      dty_s_q <= '0;
      cfg_q   <= 1'b0;
      sync_q  <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= en && wrap;
      r_q    <= en && r;
      if (load) begin
        off_s_q <= offset;
        dty_s_q <= duty;
        cfg_q   <= ({1'b0, offset} >= PER);
      end
    end
  end

  // Gate flops follow the state being entered, so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      tgt_q <= 1'b0;
      dt_q  <= '0;
      h_q   <= 1'b0;
      l_q   <= 1'b0;
    end else if (!en) begin
      st_q <= IDLE;
      h_q  <= 1'b0;
      l_q  <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          st_q  <= DT;
          tgt_q <= r_q;
          dt_q  <= DT_LOAD;
          h_q   <= 1'b0;
          l_q   <= 1'b0;
        end
        HI: begin
          if (!r_q) begin
            st_q  <= DT;
            tgt_q <= 1'b0;
            dt_q  <= DT_LOAD;
            h_q   <= 1'b0;
          end
        end
        LO: begin
          if (r_q) begin
            st_q  <= DT;
            tgt_q <= 1'b1;
            dt_q  <= DT_LOAD;
            l_q   <= 1'b0;
          end
        end
        DT: begin
          if (r_q != tgt_q) begin
            tgt_q <= r_q;
            dt_q  <= DT_LOAD;
          end else if (dt_q == '0) begin
            st_q <= tgt_q ? HI : LO;
            h_q  <= tgt_q;
            l_q  <= !tgt_q;
          end else begin
            dt_q <= dt_q - DW'(1);
          end
        end
        default: begin
          st_q <= IDLE;
          h_q  <= 1'b0;
          l_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_h   = h_q;
  assign pwm_l   = l_q;
  assign sync    = sync_q;
  assign cnt     = cnt_q;
  assign cfg_err = cfg_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen, PERIOD=20, DEAD=2.
// Expected gate patterns are hand-derived per cycle of each period.
module tb_pwm_deadtime_gen;

  localparam int P = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [12:0] offset = 13'd5;
  logic [12:0] duty = 13'd8;
  logic        pwm_h, pwm_l, sync, cfg_err;
  logic [12:0] cnt;

  int errs = 0;
  int checks = 0;

  pwm_deadtime_gen #(
    .SIZE(13),
    .PERIOD(20),
    .DEAD(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .offset(offset),
    .duty(duty),
    .pwm_h(pwm_h),
    .pwm_l(pwm_l),
    .sync(sync),
    .cnt(cnt),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_h"}, {15'd0, pwm_h}, 16'd0);
    chk({tag, "_l"}, {15'd0, pwm_l}, 16'd0);
    chk({tag, "_sync"}, {15'd0, sync}, 16'd0);
    chk({tag, "_cnt"}, {3'd0, cnt}, 16'd0);
    chk({tag, "_cfg"}, {15'd0, cfg_err}, 16'd0);
  endtask

  task automatic cyc(input string tag, input int n, input logic eh,
                     input logic el, input logic ec);
    string t;
    int p;
    logic es;
    p = n % P;
    es = (n > 0) && (p == 0);
    t = $sformatf("%s_n%0d", tag, n);
    chk({t, "_h"}, {15'd0, pwm_h}, {15'd0, eh});
    chk({t, "_l"}, {15'd0, pwm_l}, {15'd0, el});
    chk({t, "_sync"}, {15'd0, sync}, {15'd0, es});
    chk({t, "_cnt"}, {3'd0, cnt}, 16'(p));
    chk({t, "_cfg"}, {15'd0, cfg_err}, {15'd0, ec});
    step();
  endtask

  always @(negedge clk)
    if (reset_n)
      chk("nonoverlap", {15'd0, pwm_h & pwm_l}, 16'd0);

  initial begin
    int p;
    logic eh, el, ec;

    step();
    step();
    zeros("rst");
    reset_n = 1'b1;
    step();

    // basic pattern, offset 5 duty 8
    en = 1'b1;
    for (int n = 0; n < 45; n++) begin
      p = n % P;
      eh = (p >= 9) && (p <= 14);
      el = (p >= 3 && p <= 6) || p >= 17 || (n >= P && p <= 6);
      cyc("s2", n, eh, el, 1'b0);
    end
    for (int i = 0; i < 6; i++) step();
    chk("s1_midhi", {15'd0, pwm_h}, 16'd1);
    #1 reset_n = 1'b0;
    #1 zeros("s1_async");
    en = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      zeros("s1_post");
    end

    // duty change mid-period
    offset = 13'd5;
    duty = 13'd8;
    step();
    en = 1'b1;
    for (int n = 0; n < 29; n++) begin
      p = n % P;
      if (n == 10) duty = 13'd4;
      if (n < P) begin
        eh = (p >= 9) && (p <= 14);
        el = (p >= 3 && p <= 6) || p >= 17;
      end else begin
        eh = (p == 9) || (p == 10);
        el = (p <= 6) || (p >= 13);
      end
      cyc("s4", n, eh, el, 1'b0);
    end
    chk("s4_midhi", {15'd0, pwm_h}, 16'd1);
    en = 1'b0;
    step();
    chk("dis_h", {15'd0, pwm_h}, 16'd0);
    chk("dis_l", {15'd0, pwm_l}, 16'd0);
    chk("dis_cnt", {3'd0, cnt}, 16'd0);

    // wrap case, offset 15 duty 10
    offset = 13'd15;
    duty = 13'd10;
    step();
    en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      p = n % P;
      if (n < P) step();
      else cyc("s3", n, (p >= 19) || (p <= 6), (p >= 9) && (p <= 16), 1'b0);
    end
    en = 1'b0;
    step();

    // short duties, bad offset, full duty
    offset = 13'd5;
    duty = 13'd1;
    step();
    en = 1'b1;
    for (int n = 0; n < 160; n++) begin
      p = n % P;
      if (n == 40) duty = 13'd2;
      if (n == 80) begin
        offset = 13'd25;
        duty = 13'd8;
      end
      if (n == 120) begin
        offset = 13'd0;
        duty = 13'd20;
      end
      eh = 1'b0;
      ec = 1'b0;
      if (n < 100) begin
        el = (n >= 3) && !((p >= 7) && (p <= ((n >= 60) ? 10 : 9)));
      end else if (n < 140) begin
        el = 1'b1;
        ec = 1'b1;
      end else begin
        el = (n <= 141);
        eh = (n >= 144);
      end
      cyc("s56", n, eh, el, ec);
    end
    chk("s6_full", {15'd0, pwm_h}, 16'd1);
    en = 1'b0;
    step();
    chk("s6_dis_h", {15'd0, pwm_h}, 16'd0);
    chk("s6_dis_l", {15'd0, pwm_l}, 16'd0);
    chk("s6_dis_cnt", {3'd0, cnt}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
